// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: debounced button entry of two 8-bit operands (A/B),
// with auto-repeat on held up/down, feeding an adder/FND display block.
// Ports: clk; reset (sync, active-high); btn_sel/btn_up/btn_down/btn_clr
//   raw async active-high buttons; o_a/o_b operands; o_sel operand under
//   edit (0=A, 1=B); o_update one-cycle strobe whenever o_a/o_b/o_sel change.
module operand_entry_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 30_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_sel,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_clr,
   output logic [7:0] o_a,
   output logic [7:0] o_b,
   output logic       o_sel,
   output logic       o_update
);

   localparam int BSEL = 0;
   localparam int BUP  = 1;
   localparam int BDN  = 2;
   localparam int BCLR = 3;

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(REPEAT_CYCLES + 1);

   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

   typedef enum logic {
      EDIT_A = 1'b0,
      EDIT_B = 1'b1
   } state_t;

   logic [3:0]    raw;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    level;
   logic [3:0]    press;
   logic [DW-1:0] db_cnt [4];

   assign raw = {btn_clr, btn_down, btn_up, btn_sel};

   // Two-flop synchronizer for the asynchronous buttons.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce: the accepted level flips only after DEBOUNCE_CYCLES
   // consecutive samples that disagree with it; any agreeing sample
   // restarts the count. press is a registered one-cycle rise strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         level <= '0;
         press <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         press <= '0;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i] <= '0;
               level[i]  <= sync2[i];
               press[i]  <= sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   logic          hold;
   logic          rep_hit;
   logic          up_evt;
   logic          dn_evt;
   logic          any_evt;
   logic [RW-1:0] rep_cnt;

   // Repeat runs only while exactly one of up/down is held. The counter
   // restarts on every event, so repeats land REPEAT_CYCLES apart.
   assign hold    = level[BUP] ^ level[BDN];
   assign rep_hit = hold & (rep_cnt == RP_LAST)
                  & ~press[BUP] & ~press[BDN];
   assign up_evt  = press[BUP] | (rep_hit & level[BUP]);
   assign dn_evt  = press[BDN] | (rep_hit & level[BDN]);
   assign any_evt = (|press) | rep_hit;

   always_ff @(posedge clk) begin
      if (reset || !hold || any_evt) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end

   state_t     state;
   state_t     state_n;
   logic [7:0] a_n;
   logic [7:0] b_n;
   logic       upd_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EDIT_A;
         o_a      <= '0;
         o_b      <= '0;
         o_update <= 1'b0;
      end else begin
         state    <= state_n;
         o_a      <= a_n;
         o_b      <= b_n;
         o_update <= upd_n;
      end
   end

   // Priority clr > sel > up/down; up and down together cancel.
   always_comb begin
      state_n = state;
      a_n     = o_a;
      b_n     = o_b;
      if (press[BCLR]) begin
         state_n = EDIT_A;
         a_n     = '0;
         b_n     = '0;
      end else if (press[BSEL]) begin
         state_n = (state == EDIT_A) ? EDIT_B : EDIT_A;
      end else if (up_evt ^ dn_evt) begin
         if (state == EDIT_A) begin
            a_n = up_evt ? o_a + 8'd1 : o_a - 8'd1;
         end else begin
            b_n = up_evt ? o_b + 8'd1 : o_b - 8'd1;
         end
      end
      upd_n = (a_n != o_a) | (b_n != o_b) | (state_n != state);
   end

   assign o_sel = (state == EDIT_B);

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb_operand_entry_ctrl: directed and random button stimulus, checked
// every cycle against a behavioural model of the operand entry rules.
module tb_operand_entry_ctrl;

   localparam int D = 4;
   localparam int R = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn = '0;
   logic [7:0] o_a;
   logic [7:0] o_b;
   logic       o_sel;
   logic       o_update;

   int total = 0;
   int bad = 0;
   int npulse = 0;

   operand_entry_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES(R)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_sel(btn[0]),
      .btn_up(btn[1]),
      .btn_down(btn[2]),
      .btn_clr(btn[3]),
      .o_a(o_a),
      .o_b(o_b),
      .o_sel(o_sel),
      .o_update(o_update)
   );

   always #5 clk = ~clk;

   // Reference model. A button's synchronized sample is the raw input two
   // clocks earlier; its level flips when the last D samples all disagree
   // with it. Events act on the edge after they appear.
   int  m_a, m_b, old_a, old_b;
   bit  m_sel, old_sel, m_upd;
   bit  [3:0] r1, r2, samp, lvl, pe;
   bit  win [4][D];
   bit  ru, rd, hold, hold_prev, up, dn, diff;
   int  cyc = 0;
   int  anchor = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_a = 0; m_b = 0; m_sel = 0; m_upd = 0;
         r1 = '0; r2 = '0; lvl = '0; pe = '0;
         ru = 0; rd = 0; hold_prev = 0;
         for (int i = 0; i < 4; i++)
            for (int k = 0; k < D; k++) win[i][k] = 0;
         anchor = cyc;
         cyc++;
      end else begin
         old_a = m_a; old_b = m_b; old_sel = m_sel;
         up = pe[1] | ru;
         dn = pe[2] | rd;
         if (pe[3]) begin
            m_a = 0; m_b = 0; m_sel = 0;
         end else if (pe[0]) begin
            m_sel = !m_sel;
         end else if (up && !dn) begin
            if (m_sel) m_b = (m_b + 1) % 256;
            else m_a = (m_a + 1) % 256;
         end else if (dn && !up) begin
            if (m_sel) m_b = (m_b + 255) % 256;
            else m_a = (m_a + 255) % 256;
         end
         m_upd = (m_a != old_a) || (m_b != old_b) || (m_sel != old_sel);
         if (!hold_prev || pe != 0 || ru || rd) anchor = cyc;
         cyc++;
         samp = r2; r2 = r1; r1 = btn;
         for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < D - 1; k++) win[i][k] = win[i][k+1];
            win[i][D-1] = samp[i];
            diff = 1;
            for (int k = 0; k < D; k++) if (win[i][k] == lvl[i]) diff = 0;
            pe[i] = 0;
            if (diff) begin
               lvl[i] = !lvl[i];
               pe[i] = lvl[i];
            end
         end
         hold = lvl[1] ^ lvl[2];
         ru = 0; rd = 0;
         if (hold && !pe[1] && !pe[2] && (cyc - anchor == R)) begin
            ru = lvl[1];
            rd = lvl[2];
         end
         hold_prev = hold;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      total++;
      assert (o_a === 8'(m_a)) else begin
         bad++;
         $error("FAIL o_a t=%0t got %0d exp %0d", $time, o_a, m_a);
      end
      total++;
      assert (o_b === 8'(m_b)) else begin
         bad++;
         $error("FAIL o_b t=%0t got %0d exp %0d", $time, o_b, m_b);
      end
      total++;
      assert (o_sel === m_sel) else begin
         bad++;
         $error("FAIL o_sel t=%0t got %0d exp %0d", $time, o_sel, m_sel);
      end
      total++;
      assert (o_update === m_upd) else begin
         bad++;
         $error("FAIL o_update t=%0t got %0d exp %0d", $time, o_update, m_upd);
      end
      if (o_update) npulse++;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got == exp) else begin
         bad++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input int idx, input int hold_n, input int gap);
      btn[idx] = 1'b1;
      idle(hold_n);
      btn[idx] = 1'b0;
      idle(gap);
   endtask

   initial begin
      idle(3);
      chk("rst_a", o_a, 0);
      chk("rst_sel", o_sel, 0);
      reset = 1'b0;
      idle(2);

      npulse = 0;
      repeat (3) press(1, 8, 8);
      chk("three_up_a", o_a, 3);
      chk("three_up_b", o_b, 0);
      chk("three_up_sel", o_sel, 0);
      chk("three_up_pulses", npulse, 3);

      npulse = 0;
      for (int i = 0; i < 20; i++) begin
         btn[1] = ((i / 2) % 2 == 0);
         tick();
      end
      btn[1] = 1'b1;
      idle(10);
      btn[1] = 1'b0;
      idle(10);
      chk("bounce_a", o_a, 4);
      chk("bounce_pulses", npulse, 1);

      repeat (5) press(2, 8, 8);
      chk("dec_to_255", o_a, 255);
      press(1, 8, 8);
      chk("wrap_up", o_a, 0);
      press(0, 8, 8);
      press(2, 8, 8);
      chk("wrap_dn_sel", o_sel, 1);
      chk("wrap_dn_b", o_b, 255);
      chk("wrap_dn_a", o_a, 0);

      press(1, 8, 8);
      chk("b_zero", o_b, 0);
      npulse = 0;
      press(1, 40, 20);
      chk("repeat_b", o_b, 4);
      chk("repeat_pulses", npulse, 4);
      chk("repeat_a", o_a, 0);

      npulse = 0;
      btn = 4'b1011;
      idle(8);
      btn = '0;
      idle(10);
      chk("prio_a", o_a, 0);
      chk("prio_b", o_b, 0);
      chk("prio_sel", o_sel, 0);
      chk("prio_pulses", npulse, 1);

      repeat (2) press(1, 8, 8);
      chk("pre_rst_a", o_a, 2);
      btn[2] = 1'b1;
      idle(4);
      reset = 1'b1;
      idle(2);
      chk("mid_rst_a", o_a, 0);
      chk("mid_rst_upd", o_update, 0);
      reset = 1'b0;
      npulse = 0;
      idle(8);
      btn[2] = 1'b0;
      idle(12);
      chk("held_rst_a", o_a, 255);
      chk("held_rst_b", o_b, 0);
      chk("held_rst_pulses", npulse, 1);

      for (int s = 0; s < 150; s++) begin
         btn = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 3) != 0) btn[3] = 1'b0;
         if ($urandom_range(0, 19) == 0) reset = 1'b1;
         idle($urandom_range(1, 25));
         reset = 1'b0;
      end
      btn = '0;
      idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, SHALL be the number of consecutive stable synchronized samples before a button level is accepted.
REQ-002 Parameter REPEAT_CYCLES, default 30_000_000, SHALL be the auto-repeat interval for a held up/down button.
REQ-003 clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 btn_sel  input  1  SHALL be the raw, asynchronous, bouncing "toggle operand" button, active-high.
REQ-006 btn_up  input  1  SHALL be the raw "increment selected operand" button, active-high.
REQ-007 btn_down  input  1  SHALL be the raw "decrement selected operand" button, active-high.
REQ-008 btn_clr  input  1  SHALL be the raw "clear both operands" button, active-high.
REQ-009 o_a  output  8  SHALL be operand A, driving the adder/FND display block's a input.
REQ-010 o_b  output  8  SHALL be operand B, driving the adder/FND display block's b input.
REQ-011 o_sel  output  1  SHALL indicate the operand under edit: 0 = A, 1 = B.
REQ-012 o_update  output  1  SHALL pulse high for exactly one cycle in any cycle where o_a, o_b or o_sel changes.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a per-button debounce counter.
- Accepted level changes only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the current accepted level.
- Any sample equal to the accepted level SHALL restart that button's count.
REQ-014 A press event SHALL be a 0->1 transition of the accepted level, one cycle wide; latency from a stable raw edge to the event SHALL be 2 + DEBOUNCE_CYCLES cycles, ±1.
REQ-015 The FSM SHALL have two states, EDIT_A and EDIT_B; o_sel SHALL be 0 in EDIT_A and 1 in EDIT_B.
- A sel event SHALL toggle the state.
- A clr event SHALL force EDIT_A.
REQ-016 An up event SHALL add 1 modulo 256 to the selected operand (255 -> 0); the other operand SHALL be unchanged.
REQ-017 A down event SHALL subtract 1 modulo 256 (0 -> 255); the other operand SHALL be unchanged.
REQ-018 A clr event SHALL set o_a = 0 and o_b = 0.
REQ-019 Outputs SHALL update on the clock edge following the event cycle; o_update SHALL assert in that same updated cycle.
REQ-020 Simultaneous events in one cycle SHALL resolve by priority clr > sel > up/down; only the winning action SHALL take effect.
REQ-021 Simultaneous up and down events with no clr/sel SHALL cause no change and no o_update.
REQ-022 Auto-repeat: while the up (or down) accepted level stays high and the other stays low, a repeat event SHALL fire every REPEAT_CYCLES cycles after the initial press event.
- Repeat events SHALL be processed identically to press events.
REQ-023 The repeat counter SHALL reset on release, on any sel or clr event, and when both up and down are held.
REQ-024 A clr or sel event SHALL NOT alter the operand value currently under edit, other than the clear performed by clr.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL set:
- o_a = 0, o_b = 0, o_sel = 0 (EDIT_A), o_update = 0;
- all synchronizers, accepted levels, debounce counters and repeat counters = 0.
REQ-026 A button held through reset deassertion SHALL be debounced afresh and SHALL generate one press event after 2 + DEBOUNCE_CYCLES cycles.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard the pending count, with no event emitted.

Verification (DEBOUNCE_CYCLES = 4, REPEAT_CYCLES = 10)
REQ-028 Reset, then 3 clean up presses -> o_a = 3, o_b = 0, o_sel = 0, with three single-cycle o_update pulses.
REQ-029 btn_up bouncing 0/1 every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one increment.
REQ-030 o_a = 255 with one up press -> o_a = 0; then sel and one down press -> o_sel = 1, o_b = 255, o_a unchanged.
REQ-031 Hold btn_up 40 cycles in EDIT_B from o_b = 0 -> o_b = 1 at press, then +1 every 10 cycles (o_b = 4 before release), no change after release.
REQ-032 clr, sel and up accepted in the same cycle -> o_a = 0, o_b = 0, o_sel = 0, one o_update pulse.
REQ-033 Reset asserted while btn_down is held mid-debounce -> all outputs 0; after release of reset with btn_down still high, exactly one decrement -> o_a = 255.
